scene_query_multi: RTL

- Parametrised successor to the single-sphere scene query. Evaluates a ray-march sample point against a register-loaded table of up to N_OBJECTS spheres.
- Returns the minimum signed distance and the index of the closest object.
- Shares one pipelined sphere-SDF unit across all objects, one object issued per cycle. Uses valid/ready handshakes on both sides so the ray-march stepper can stall it.

---
 rtl/scene_pkg.sv | 35 +++
 rtl/scene_query_multi_if.sv | 26 ++
 rtl/sdf_sphere_pipe.sv | 61 ++++++
 rtl/scene_query_multi.sv | 117 +++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// scene_pkg: fixed-point scene types, constants and the integer square root shared by the scene query
package scene_pkg;
   typedef logic signed [31:0] fp_t;
   typedef struct packed {
      fp_t x;
      fp_t y;
      fp_t z;
   } vec3_t;
   typedef struct packed {
      vec3_t centre;
      fp_t   radius;
      logic  enable;
   } sphere_entry_t;
   localparam fp_t FP_MAX = 32'sh7FFFFFFF;
   localparam fp_t FP_MIN = 32'sh80000000;
   localparam fp_t FP_ONE = 32'sh01000000;
   localparam fp_t DEFAULT_RADIUS = 32'sh0019999A;
   localparam int SDF_SPHERE_LATENCY = 4;
   function automatic logic [45:0] isqrt(input logic [91:0] v);
      logic [47:0] rem;
      logic [45:0] root;
      rem = '0;
      root = '0;
      for (int i = 45; i >= 0; i--) begin
         rem = {rem[45:0], v[2*i+1 -: 2]};
         if (rem >= {root, 2'b01}) begin
            rem = rem - {root, 2'b01};
            root = {root[44:0], 1'b1};
         end else begin
            root = {root[44:0], 1'b0};
         end
      end
      return root;
   endfunction
endpackage

// File: rtl/scene_query_multi_if.sv
// scene_query_multi_if: query, table-config and result handshakes of the multi-sphere scene query
interface scene_query_multi_if #(parameter int ID_W = 3);
   import scene_pkg::*;
   logic            in_valid;
   logic            in_ready;
   vec3_t           pos;
   logic            cfg_we;
   logic            cfg_ready;
   logic [ID_W-1:0] cfg_addr;
   vec3_t           cfg_centre;
   fp_t             cfg_radius;
   logic            cfg_enable;
   logic            out_valid;
   logic            out_ready;
   fp_t             closest_distance;
   logic [ID_W-1:0] closest_id;
   logic            no_object;
   modport master (
      output in_valid, pos, cfg_we, cfg_addr, cfg_centre, cfg_radius, cfg_enable, out_ready,
      input  in_ready, cfg_ready, out_valid, closest_distance, closest_id, no_object
   );
   modport slave (
      input  in_valid, pos, cfg_we, cfg_addr, cfg_centre, cfg_radius, cfg_enable, out_ready,
      output in_ready, cfg_ready, out_valid, closest_distance, closest_id, no_object
   );
endinterface

// File: rtl/sdf_sphere_pipe.sv
// sdf_sphere_pipe: four-stage sphere signed-distance evaluator carrying a tag alongside each sample
module sdf_sphere_pipe import scene_pkg::*; #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   input  vec3_t            p,
   input  vec3_t            centre,
   input  fp_t              radius,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output fp_t              distance
);
   logic [3:0]        v;
   logic [TAG_W-1:0]  t1, t2, t3;
   logic signed [32:0] dx, dy, dz;
   fp_t               r1, r2, r3, s3, s, dist_n;
   logic [66:0]       sum, sum2;
   logic signed [65:0] qx, qy, qz;
   logic [45:0]       root;
   logic signed [32:0] diff;

   assign out_valid = v[3];

   // squares and sum, square root with saturation, then saturating radius subtract
   always_comb begin
      qx = 66'(dx) * 66'(dx);
      qy = 66'(dy) * 66'(dy);
      qz = 66'(dz) * 66'(dz);
      sum = 67'(qx >>> 24) + 67'(qy >>> 24) + 67'(qz >>> 24);
      root = isqrt({1'b0, sum2, 24'b0});
      s = (|root[45:31]) ? FP_MAX : {1'b0, root[30:0]};
      diff = 33'(s3) - 33'(r3);
      dist_n = (diff[32] ^ diff[31]) ? (diff[32] ? FP_MIN : FP_MAX) : diff[31:0];
   end

   // stage valid bits are the only state that must clear on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v <= '0;
      else v <= {v[2:0], in_valid};
   end

   // stage data registers: differences, sum of squares, root, distance
   always_ff @(posedge clk) begin
      t1 <= in_tag;
      r1 <= radius;
      dx <= 33'(p.x) - 33'(centre.x);
      dy <= 33'(p.y) - 33'(centre.y);
      dz <= 33'(p.z) - 33'(centre.z);
      t2 <= t1;
      r2 <= r1;
      sum2 <= sum;
      t3 <= t2;
      r3 <= r2;
      s3 <= s;
      out_tag <= t3;
      distance <= dist_n;
   end
endmodule

// File: rtl/scene_query_multi.sv
// scene_query_multi: minimum signed distance and closest index over a table of spheres
module scene_query_multi import scene_pkg::*; #(
   parameter int N_OBJECTS = 8,
   parameter int ID_W = (N_OBJECTS > 1) ? $clog2(N_OBJECTS) : 1,
   localparam int SDF_LAT = SDF_SPHERE_LATENCY
) (
   input logic clk,
   input logic rst_n,
   scene_query_multi_if.slave q
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t          state, state_d;
   logic [6:0]      cnt, cnt_d;
   sphere_entry_t   tbl [N_OBJECTS];
   sphere_entry_t   cur;
   vec3_t           pos_q;
   logic            accept, cfg_wr;
   fp_t             acc_d;
   logic [ID_W-1:0] acc_id;
   logic            acc_valid;
   logic            res_valid;
   logic [ID_W:0]   res_tag;
   fp_t             res_d;

   // next state, issue counter and handshake outputs
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      q.in_ready = state == IDLE;
      q.cfg_ready = state == IDLE;
      q.out_valid = state == DONE;
      accept = q.in_valid && state == IDLE;
      cfg_wr = q.cfg_we && state == IDLE;
      cur = tbl[cnt[ID_W-1:0]];
      case (state)
         IDLE: if (accept) begin
            state_d = ISSUE;
            cnt_d = '0;
         end
         ISSUE: begin
            cnt_d = cnt + 7'd1;
            if (cnt == 7'(N_OBJECTS - 1)) begin
               state_d = DRAIN;
               cnt_d = '0;
            end
         end
         DRAIN: begin
            cnt_d = cnt + 7'd1;
            if (cnt == 7'(SDF_LAT)) state_d = DONE;
         end
         DONE: if (q.out_ready) state_d = IDLE;
      endcase
   end

   // state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
      end
   end

   // sphere table: only writable while idle, so a query always sees a frozen table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OBJECTS; i++) tbl[i] <= '0;
         tbl[0] <= '{centre: '0, radius: DEFAULT_RADIUS, enable: 1'b1};
      end else if (cfg_wr && 32'(q.cfg_addr) < 32'(N_OBJECTS)) begin
         tbl[q.cfg_addr] <= '{q.cfg_centre, q.cfg_radius, q.cfg_enable};
      end
   end

   sdf_sphere_pipe #(.TAG_W(ID_W + 1)) u_sdf (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (state == ISSUE),
      .in_tag   ({cur.enable, cnt[ID_W-1:0]}),
      .p        (pos_q),
      .centre   (cur.centre),
      .radius   (cur.radius),
      .out_valid(res_valid),
      .out_tag  (res_tag),
      .distance (res_d)
   );

   // query latch, strict signed min-reduction and result capture on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= '0;
         acc_d <= FP_MAX;
         acc_id <= '0;
         acc_valid <= 1'b0;
         q.closest_distance <= '0;
         q.closest_id <= '0;
         q.no_object <= 1'b0;
      end else begin
         if (accept) begin
            pos_q <= q.pos;
            acc_d <= FP_MAX;
            acc_id <= '0;
            acc_valid <= 1'b0;
         end else if (res_valid && res_tag[ID_W] && (!acc_valid || res_d < acc_d)) begin
            acc_d <= res_d;
            acc_id <= res_tag[ID_W-1:0];
            acc_valid <= 1'b1;
         end
         if (state == DRAIN && state_d == DONE) begin
            q.closest_distance <= acc_d;
            q.closest_id <= acc_id;
            q.no_object <= !acc_valid;
         end
      end
   end
endmodule
